multi_dev_bridge: RTL and testbench
===================================

// Module: multi_dev_bridge
// PURPOSE
//  Parametrised CPU-to-device bridge for the MIPS microsystem. Decodes the CPU word address into NDEV
//  uniform device windows and runs one registered strobe/ack transaction per access, with a per-access
//  timeout and a bus-error flag. Also registers device IRQ lines onto HWInt[7:2]. It sits between the
//  CPU data port (Pr* side) and the timer, switch, segment and future devices.
// PARAMETERS
//  NDEV     4            number of device channels, 1..6 (channel i drives HWInt bit i+2)
//  BASE     30'h0000_1FC0  word address of channel 0 (byte 0x7F00); aligned to 2^(SPAN_W+IDX_W)
//  SPAN_W   2            log2 of words per device window (4 words = 16 bytes)
//  TIMEOUT  15           maximum ACCESS cycles waiting for dev_ack, >=1
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high
//  pr_req      in   1          CPU request; held with fields stable until pr_rdy
//  pr_wen      in   1          1 = write, 0 = read
//  pr_addr     in   30         word address, PrAddr[31:2]
//  pr_be       in   4          byte enables
//  pr_dout     in   32         CPU write data
//  pr_din      out  32         read data, valid when pr_rdy=1
//  pr_rdy      out  1          one-cycle completion pulse
//  pr_err      out  1          qualifies pr_rdy: unmapped address or timeout
//  dev_stb     out  NDEV       one-hot access strobe
//  dev_we      out  1          write qualifier for dev_stb
//  dev_addr    out  SPAN_W     word offset inside the window
//  dev_be      out  4          byte enables to the device
//  dev_dat_i   out  32         write data to the devices
//  dev_dat_o   in   NDEV*32    flattened read data; channel i is bits [32*i+31:32*i]
//  dev_ack     in   NDEV       per-channel completion
//  dev_irq     in   NDEV       level interrupt requests
//  hwint       out  6          HWInt[7:2] to CP0
// BEHAVIOUR
//  Decode (IDX_W = clog2(NDEV))
//   - hit when pr_addr[29:SPAN_W+IDX_W] == BASE[29:SPAN_W+IDX_W] and idx = pr_addr[SPAN_W+IDX_W-1:SPAN_W] < NDEV.
//  FSM states: IDLE, ACCESS, RESP
//   - IDLE: pr_req=1 latches wen/addr/be/dout and idx.
//     - If hit: go to ACCESS and clear cnt.
//     - If no hit: go to RESP with err=1 and data 0.
//   - ACCESS: dev_stb[idx]=1; dev_we, dev_addr, dev_be, dev_dat_i come from the latched fields.
//     - dev_ack[idx]=1: capture dev_dat_o[idx] (writes capture 0) and go to RESP with err=0.
//     - No ack and cnt==TIMEOUT-1: go to RESP with err=1 and data 0. Otherwise cnt++.
//   - RESP: pr_rdy=1 with registered pr_din/pr_err for exactly one cycle, then IDLE.
//  Latency and handshake
//   - Minimum latency: req sampled at edge t, stb high in cycle t+1, ack in t+1, pr_rdy in t+2.
//   - Unmapped access: pr_rdy in t+1. Timeout: pr_rdy TIMEOUT+1 cycles after the accepting edge.
//   - dev_stb is high for at most TIMEOUT cycles.
//   - pr_req is ignored in ACCESS and RESP. The requester drops pr_req after pr_rdy; if it is still
//     high in IDLE, that is a new transaction.
//  Ignored inputs
//   - dev_ack from a non-selected channel, and any ack arriving outside ACCESS (late ack after timeout).
//  Byte enables: pr_be is forwarded unchanged, including 4'b0000 (still a full transaction).
//  Interrupts: hwint[i] <= dev_irq[i] for i<NDEV; bits NDEV..5 are 0. One cycle latency, no masking.
//  Reset (asynchronous, any state):
//   - state=IDLE, cnt=0.
//   - pr_rdy, pr_err, pr_din, dev_stb, dev_we, dev_addr, dev_be, dev_dat_i and hwint all 0.
//   - An in-flight access is abandoned with no pr_rdy.
// STRUCTURE
//  - Package bridge_pkg: state encoding (IDLE/ACCESS/RESP), DEFAULT_BASE, DATA_W=32, HWINT_W=6.
//  - Sub-module bridge_decode: combinational; inputs pr_addr; outputs hit and idx. Parametrised by
//    NDEV, BASE and SPAN_W; unit-testable alone.
//  - Top level holds the FSM, timeout counter, latched request, response registers and IRQ register.
// TESTING
//  1. Read ch0 at word 0x1FC1 (byte 0x7F04), device acks in the first ACCESS cycle with 32'hDEADBEEF
//     -> dev_stb=4'b0001 and dev_addr=1; pr_rdy 2 cycles after acceptance with pr_din=32'hDEADBEEF, pr_err=0.
//  2. Write ch2 at byte 0x7F28, be=4'b0011, data 32'h1234_5678, ack after 3 cycles
//     -> dev_stb=4'b0100 and dev_we=1 for 3 cycles, dev_addr=2, dev_be=4'b0011; pr_rdy with pr_err=0.
//  3. Read byte 0x7F40 (idx 4 >= NDEV), then byte 0x8000 -> each gives pr_rdy 1 cycle after
//     acceptance, pr_err=1, pr_din=0, and no dev_stb activity.
//  4. Read ch1, no ack, TIMEOUT=15 -> dev_stb[1] high for exactly 15 cycles; pr_rdy with pr_err=1 and
//     pr_din=0. dev_ack[1] pulsed 2 cycles later -> no effect, FSM remains IDLE.
//  5. During ch3's ACCESS: dev_ack[0]=1 and pr_req re-pulsed -> both ignored; completes only on dev_ack[3].
//     Then reset asserted mid-ACCESS -> all outputs 0 at once and no pr_rdy.
//  6. dev_irq=4'b1010 -> hwint=6'b001010 one cycle later; with NDEV=6 and dev_irq=6'h3F -> hwint=6'h3F.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-device bridge.
package bridge_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HWINT_W = 6;
  localparam logic [29:0] DEFAULT_BASE = 30'h0000_1FC0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// Address decoder: maps a CPU word address onto one of NDEV uniform windows.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int unsigned NDEV   = 4,
  parameter logic [29:0] BASE   = DEFAULT_BASE,
  parameter int unsigned SPAN_W = 2
) (
  input  logic [29:0]             pr_addr,
  output logic                    hit,
  output logic [idx_w(NDEV)-1:0]  idx
);

  localparam int unsigned DEC_W = $clog2(NDEV);
  localparam int unsigned IW    = idx_w(NDEV);
  localparam int unsigned SH    = SPAN_W + DEC_W;

  logic [29:0] idx_raw_c;

  // Upper bits must match the base block; the index field must name an existing channel.
  always_comb begin
    idx_raw_c = (pr_addr >> SPAN_W) & ((30'd1 << DEC_W) - 30'd1);
    hit       = ((pr_addr >> SH) == (BASE >> SH)) && (idx_raw_c < 30'(NDEV));
    idx       = IW'(idx_raw_c);
  end

endmodule

// File: rtl/multi_dev_bridge.sv
// CPU-to-device bridge: one strobe/ack transaction per access with timeout, plus IRQ registering.
module multi_dev_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned NDEV    = 4,
  parameter logic [29:0] BASE    = DEFAULT_BASE,
  parameter int unsigned SPAN_W  = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pr_req,
  input  logic                   pr_wen,
  input  logic [29:0]            pr_addr,
  input  logic [3:0]             pr_be,
  input  logic [31:0]            pr_dout,
  output logic [31:0]            pr_din,
  output logic                   pr_rdy,
  output logic                   pr_err,
  output logic [NDEV-1:0]        dev_stb,
  output logic                   dev_we,
  output logic [SPAN_W-1:0]      dev_addr,
  output logic [3:0]             dev_be,
  output logic [31:0]            dev_dat_i,
  input  logic [NDEV*32-1:0]     dev_dat_o,
  input  logic [NDEV-1:0]        dev_ack,
  input  logic [NDEV-1:0]        dev_irq,
  output logic [5:0]             hwint
);

  localparam int unsigned IW    = idx_w(NDEV);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IW-1:0]      idx_q;
  logic               hit_c;
  logic [IW-1:0]      idx_c;
  logic               ack_c;
  logic [DATA_W-1:0]  rdata_c;

  bridge_decode #(
    .NDEV   (NDEV),
    .BASE   (BASE),
    .SPAN_W (SPAN_W)
  ) u_decode (
    .pr_addr (pr_addr),
    .hit     (hit_c),
    .idx     (idx_c)
  );

  // Select ack and read data of the latched channel only; other channels are ignored.
  always_comb begin
    ack_c   = 1'b0;
    rdata_c = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (idx_q == IW'(i)) begin
        ack_c   = dev_ack[i];
        rdata_c = dev_dat_o[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered device strobes and CPU response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      pr_rdy    <= 1'b0;
      pr_err    <= 1'b0;
      pr_din    <= '0;
      dev_stb   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_be    <= '0;
      dev_dat_i <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pr_req) begin
            dev_we    <= pr_wen;
            dev_addr  <= SPAN_W'(pr_addr);
            dev_be    <= pr_be;
            dev_dat_i <= pr_dout;
            idx_q     <= idx_c;
            cnt       <= '0;
            if (hit_c) begin
              state   <= ST_ACCESS;
              dev_stb <= NDEV'(1) << idx_c;
            end else begin
              state  <= ST_RESP;
              pr_rdy <= 1'b1;
              pr_err <= 1'b1;
              pr_din <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_c) begin
            state   <= ST_RESP;
            dev_stb <= '0;
            pr_rdy  <= 1'b1;
            pr_err  <= 1'b0;
            pr_din  <= dev_we ? '0 : rdata_c;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= ST_RESP;
            dev_stb <= '0;
            pr_rdy  <= 1'b1;
            pr_err  <= 1'b1;
            pr_din  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          pr_rdy <= 1'b0;
          pr_err <= 1'b0;
          pr_din <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Device interrupt lines onto HWInt[7:2], one cycle late, unused bits zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hwint <= '0;
    else       hwint <= HWINT_W'(dev_irq);
  end

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Directed testbench for multi_dev_bridge with hand-computed expectations.
module tb_multi_dev_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         pr_req, pr_wen;
  logic [29:0]  pr_addr;
  logic [3:0]   pr_be;
  logic [31:0]  pr_dout, pr_din;
  logic         pr_rdy, pr_err;
  logic [3:0]   dev_stb;
  logic         dev_we;
  logic [1:0]   dev_addr;
  logic [3:0]   dev_be;
  logic [31:0]  dev_dat_i;
  logic [127:0] dev_dat_o;
  logic [3:0]   dev_ack, dev_irq;
  logic [5:0]   hwint;

  // Six-channel instance used for the interrupt width check.
  logic         req6;
  logic [31:0]  din6;
  logic         rdy6, err6, we6;
  logic [5:0]   stb6, ack6, irq6, hwint6;
  logic [1:0]   addr6;
  logic [3:0]   be6;
  logic [31:0]  dati6;
  logic [191:0] dato6;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction observations.
  int          r_lat, r_stb_cyc, r_we_cyc;
  logic [3:0]  r_stb_seen, r_be;
  logic [1:0]  r_addr;
  logic [31:0] r_dat_i, r_din;
  logic        r_err, r_rdy;

  always #5 clk = ~clk;

  multi_dev_bridge u_dut (
    .clk(clk), .reset(reset), .pr_req(pr_req), .pr_wen(pr_wen), .pr_addr(pr_addr),
    .pr_be(pr_be), .pr_dout(pr_dout), .pr_din(pr_din), .pr_rdy(pr_rdy), .pr_err(pr_err),
    .dev_stb(dev_stb), .dev_we(dev_we), .dev_addr(dev_addr), .dev_be(dev_be),
    .dev_dat_i(dev_dat_i), .dev_dat_o(dev_dat_o), .dev_ack(dev_ack), .dev_irq(dev_irq),
    .hwint(hwint)
  );

  multi_dev_bridge #(.NDEV(6)) u_dut6 (
    .clk(clk), .reset(reset), .pr_req(req6), .pr_wen(1'b0), .pr_addr(30'd0),
    .pr_be(4'd0), .pr_dout(32'd0), .pr_din(din6), .pr_rdy(rdy6), .pr_err(err6),
    .dev_stb(stb6), .dev_we(we6), .dev_addr(addr6), .dev_be(be6),
    .dev_dat_i(dati6), .dev_dat_o(dato6), .dev_ack(ack6), .dev_irq(irq6),
    .hwint(hwint6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; ack channel ack_ch in the ack_at-th strobe cycle (-1 = never).
  task automatic run_xfer(input logic [29:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] d, input int ack_at, input int ack_ch);
    pr_req = 1'b1; pr_wen = w; pr_addr = a; pr_be = be; pr_dout = d;
    step();
    pr_req = 1'b0;
    r_lat = 1; r_stb_cyc = 0; r_we_cyc = 0; r_stb_seen = '0;
    r_addr = '0; r_be = '0; r_dat_i = '0;
    while (!pr_rdy && r_lat < 40) begin
      if (dev_stb != 4'd0) begin
        r_stb_cyc++;
        if (dev_we) r_we_cyc++;
        r_stb_seen = r_stb_seen | dev_stb;
        r_addr = dev_addr; r_be = dev_be; r_dat_i = dev_dat_i;
      end
      dev_ack = (r_stb_cyc == ack_at) ? (4'd1 << ack_ch) : 4'd0;
      step();
      r_lat++;
    end
    dev_ack = 4'd0;
    r_rdy = pr_rdy; r_din = pr_din; r_err = pr_err;
  endtask

  initial begin
    reset = 1'b1; pr_req = 0; pr_wen = 0; pr_addr = '0; pr_be = '0; pr_dout = '0;
    dev_dat_o = '0; dev_ack = '0; dev_irq = '0;
    req6 = 0; ack6 = '0; irq6 = '0; dato6 = '0;
    step(); step();
    check("rst_rdy", 32'(pr_rdy), 32'd0);
    check("rst_stb", 32'(dev_stb), 32'd0);
    check("rst_hwint", 32'(hwint), 32'd0);
    reset = 1'b0;
    step();

    // 1: read ch0 word 0x1FC1, immediate ack
    dev_dat_o[31:0] = 32'hDEADBEEF;
    run_xfer(30'h1FC1, 1'b0, 4'hF, 32'h0, 1, 0);
    check("t1_stb", 32'(r_stb_seen), 32'h1);
    check("t1_addr", 32'(r_addr), 32'd1);
    check("t1_lat", 32'(r_lat), 32'd2);
    check("t1_rdy", 32'(r_rdy), 32'd1);
    check("t1_din", r_din, 32'hDEADBEEF);
    check("t1_err", 32'(r_err), 32'd0);
    step();
    check("t1_rdy_pulse", 32'(pr_rdy), 32'd0);

    // 2: write ch2 byte 0x7F28, ack in third strobe cycle
    dev_dat_o[95:64] = 32'hFFFF_0000;
    run_xfer(30'h1FCA, 1'b1, 4'b0011, 32'h1234_5678, 3, 2);
    check("t2_stb", 32'(r_stb_seen), 32'h4);
    check("t2_stb_cyc", 32'(r_stb_cyc), 32'd3);
    check("t2_we_cyc", 32'(r_we_cyc), 32'd3);
    check("t2_addr", 32'(r_addr), 32'd2);
    check("t2_be", 32'(r_be), 32'h3);
    check("t2_dat", r_dat_i, 32'h1234_5678);
    check("t2_lat", 32'(r_lat), 32'd4);
    check("t2_err", 32'(r_err), 32'd0);
    check("t2_din", r_din, 32'd0);
    step();

    // 3: unmapped reads at byte 0x7F40 and 0x8000
    run_xfer(30'h1FD0, 1'b0, 4'hF, 32'h0, -1, 0);
    check("t3a_lat", 32'(r_lat), 32'd1);
    check("t3a_err", 32'(r_err), 32'd1);
    check("t3a_din", r_din, 32'd0);
    check("t3a_stb", 32'(r_stb_seen), 32'd0);
    step();
    run_xfer(30'h2000, 1'b0, 4'hF, 32'h0, -1, 0);
    check("t3b_lat", 32'(r_lat), 32'd1);
    check("t3b_err", 32'(r_err), 32'd1);
    check("t3b_stb", 32'(r_stb_seen), 32'd0);
    step();

    // 4: read ch1 with no ack -> timeout, then a late ack is ignored
    dev_dat_o[63:32] = 32'h5555_AAAA;
    run_xfer(30'h1FC4, 1'b0, 4'b0000, 32'h0, -1, 1);
    check("t4_stb_cyc", 32'(r_stb_cyc), 32'd15);
    check("t4_stb", 32'(r_stb_seen), 32'h2);
    check("t4_be", 32'(r_be), 32'h0);
    check("t4_lat", 32'(r_lat), 32'd16);
    check("t4_rdy", 32'(r_rdy), 32'd1);
    check("t4_err", 32'(r_err), 32'd1);
    check("t4_din", r_din, 32'd0);
    step();
    dev_ack = 4'b0010;
    step();
    dev_ack = 4'b0000;
    check("t4_late_rdy", 32'(pr_rdy), 32'd0);
    check("t4_late_stb", 32'(dev_stb), 32'd0);
    step();
    check("t4_late_rdy2", 32'(pr_rdy), 32'd0);

    // 5: ch3 access ignores foreign ack and re-pulsed request
    dev_dat_o[127:96] = 32'hCAFE_0003;
    dev_dat_o[31:0]   = 32'h0BAD_0000;
    pr_req = 1'b1; pr_wen = 1'b0; pr_addr = 30'h1FCC; pr_be = 4'hF;
    step();
    pr_req = 1'b0;
    dev_ack = 4'b0001;
    step();
    dev_ack = 4'b0000;
    check("t5_stb_hold", 32'(dev_stb), 32'h8);
    check("t5_no_rdy", 32'(pr_rdy), 32'd0);
    pr_req = 1'b1; pr_addr = 30'h1FC1;
    step();
    pr_req = 1'b0;
    check("t5_stb_hold2", 32'(dev_stb), 32'h8);
    dev_ack = 4'b1000;
    step();
    dev_ack = 4'b0000;
    check("t5_rdy", 32'(pr_rdy), 32'd1);
    check("t5_din", pr_din, 32'hCAFE_0003);
    check("t5_err", 32'(pr_err), 32'd0);
    step();
    check("t5_idle_rdy", 32'(pr_rdy), 32'd0);
    check("t5_idle_stb", 32'(dev_stb), 32'd0);

    // 5b: reset in the middle of an access
    pr_req = 1'b1; pr_wen = 1'b1; pr_addr = 30'h1FCD; pr_be = 4'hA; pr_dout = 32'h7777_7777;
    dev_irq = 4'b0101;
    step();
    pr_req = 1'b0;
    check("t5r_stb_pre", 32'(dev_stb), 32'h8);
    check("t5r_hwint_pre", 32'(hwint), 32'h05);
    #2 reset = 1'b1;
    #1;
    check("t5r_stb", 32'(dev_stb), 32'd0);
    check("t5r_we", 32'(dev_we), 32'd0);
    check("t5r_addr", 32'(dev_addr), 32'd0);
    check("t5r_be", 32'(dev_be), 32'd0);
    check("t5r_dat", dev_dat_i, 32'd0);
    check("t5r_hwint", 32'(hwint), 32'd0);
    step();
    reset = 1'b0;
    dev_irq = 4'b0000;
    step();
    check("t5r_no_rdy", 32'(pr_rdy), 32'd0);
    step();
    check("t5r_no_rdy2", 32'(pr_rdy), 32'd0);
    check("t5r_stb_idle", 32'(dev_stb), 32'd0);

    // 6: interrupts
    dev_irq = 4'b1010;
    irq6 = 6'h3F;
    #1;
    check("t6_hwint_before", 32'(hwint), 32'd0);
    step();
    check("t6_hwint", 32'(hwint), 32'h0A);
    check("t6_hwint6", 32'(hwint6), 32'h3F);
    dev_irq = 4'b0001;
    irq6 = 6'h21;
    step();
    check("t6_hwint_b", 32'(hwint), 32'h01);
    check("t6_hwint6_b", 32'(hwint6), 32'h21);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
